// File: rtl/rom_reader_pkg.sv
// Shared constants and types for the 556PT5/556PT4 PROM reader.
package rom_reader_pkg;

    // 556PT5 (3604): 512 x 8
    localparam int unsigned IP3604_DATA_WIDTH    = 8;
    localparam int unsigned IP3604_ADDRESS_WIDTH = 9;
    localparam int unsigned IP3604_LAST_ADDRESS  = 511;

    // 556PT4 (3601): 256 x 4
    localparam int unsigned IP3601_DATA_WIDTH    = 4;
    localparam int unsigned IP3601_ADDRESS_WIDTH = 8;
    localparam int unsigned IP3601_LAST_ADDRESS  = 255;

    // V1..V4 codes: read enables the outputs, idle deselects the chip
    localparam logic [3:0] OP_READ = 4'b1100;
    localparam logic [3:0] OP_IDLE = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSettle,
        StSample,
        StPresent,
        StNext
    } reader_state_e;

    typedef enum logic {
        ModeSweep,
        ModeSingle
    } reader_mode_e;

    // The op code is registered on leaving SETUP and data is captured on leaving SAMPLE,
    // so SETTLE has to last settle_cycles-1 cycles: count from settle_cycles-2 down to 0.
    function automatic int unsigned settle_load(input int unsigned settle_cycles);
        return (settle_cycles >= 32'd2) ? settle_cycles - 32'd2 : 32'd0;
    endfunction

endpackage

// File: rtl/rom_settle_timer.sv
// Down-counter used to hold the chip in SETTLE for a fixed number of cycles.
module rom_settle_timer #(
    parameter int unsigned COUNT_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   decrement,
    output logic                   zero
);

    logic [COUNT_WIDTH-1:0] count_q;

    // Load has priority; the count saturates at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (decrement && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/rom_sweep_reader.sv
// PROM reader: drives address and op code, waits for the access time, samples the data bus
// and hands (address, data) downstream over a valid/ready handshake.
module rom_sweep_reader
    import rom_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = IP3604_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = IP3604_ADDRESS_WIDTH,
    parameter int unsigned LAST_ADDRESS  = IP3604_LAST_ADDRESS,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  READ_OP       = OP_READ,
    parameter logic [3:0]  IDLE_OP       = OP_IDLE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     step_up,
    input  logic                     step_down,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    sample_data,
    output logic [ADDRESS_WIDTH-1:0] sample_address,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(settle_load(SETTLE_CYCLES));
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(LAST_ADDRESS);

    reader_state_e            state_q, state_d;
    reader_mode_e             mode_q, mode_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [3:0]               operation_q, operation_d;
    logic [DATA_WIDTH-1:0]    sample_data_q, sample_data_d;
    logic [ADDRESS_WIDTH-1:0] sample_address_q, sample_address_d;
    logic                     sample_valid_q, sample_valid_d;
    logic                     abort_q, abort_d;
    logic                     done_q, done_d;

    logic                     timer_load, timer_dec, timer_zero;
    logic                     abort_pend;
    logic [ADDRESS_WIDTH-1:0] address_inc, address_dec;

    rom_settle_timer #(
        .COUNT_WIDTH(CNT_W)
    ) u_settle_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (timer_load),
        .load_value(SETTLE_LOAD),
        .decrement (timer_dec),
        .zero      (timer_zero)
    );

    // Wrap explicitly at LAST_ADDRESS, which need not be a power-of-two boundary.
    assign address_inc = (address_q == LAST_ADDR) ? '0 : address_q + 1'b1;
    assign address_dec = (address_q == '0) ? LAST_ADDR : address_q - 1'b1;
    assign abort_pend  = abort_q | abort;

    // Next-state, address sequencing, sample capture and abort handling.
    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        address_d        = address_q;
        operation_d      = operation_q;
        sample_data_d    = sample_data_q;
        sample_address_d = sample_address_q;
        sample_valid_d   = sample_valid_q;
        abort_d          = abort_q | (abort & (state_q != StIdle));
        done_d           = 1'b0;
        timer_load       = 1'b0;
        timer_dec        = 1'b0;

        unique case (state_q)
            StIdle: begin
                operation_d = IDLE_OP;
                abort_d     = 1'b0;
                if (start) begin
                    address_d = '0;
                    mode_d    = ModeSweep;
                    state_d   = StSetup;
                end else if (step_up && !step_down) begin
                    address_d = address_inc;
                    mode_d    = ModeSingle;
                    state_d   = StSetup;
                end else if (step_down && !step_up) begin
                    address_d = address_dec;
                    mode_d    = ModeSingle;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (abort_pend) begin
                    state_d     = StIdle;
                    operation_d = IDLE_OP;
                    abort_d     = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    operation_d = READ_OP;
                    timer_load  = 1'b1;
                    state_d     = StSettle;
                end
            end
            StSettle: begin
                if (abort_pend) begin
                    state_d     = StIdle;
                    operation_d = IDLE_OP;
                    abort_d     = 1'b0;
                    done_d      = 1'b1;
                end else if (timer_zero) begin
                    state_d = StSample;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            StSample: begin
                // An abort arriving here stays latched until the sample is handed off.
                sample_data_d    = data_line_in;
                sample_address_d = address_q;
                sample_valid_d   = 1'b1;
                state_d          = StPresent;
            end
            StPresent: begin
                if (sample_ready) begin
                    sample_valid_d = 1'b0;
                    if (abort_pend) begin
                        state_d     = StIdle;
                        operation_d = IDLE_OP;
                        abort_d     = 1'b0;
                        done_d      = 1'b1;
                    end else if (mode_q == ModeSingle) begin
                        state_d     = StIdle;
                        operation_d = IDLE_OP;
                    end else if (address_q == LAST_ADDR) begin
                        state_d     = StIdle;
                        operation_d = IDLE_OP;
                        done_d      = 1'b1;
                    end else begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                if (abort_pend) begin
                    state_d     = StIdle;
                    operation_d = IDLE_OP;
                    abort_d     = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    address_d = address_inc;
                    state_d   = StSetup;
                end
            end
            default: begin
                state_d     = StIdle;
                operation_d = IDLE_OP;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            mode_q           <= ModeSweep;
            address_q        <= '0;
            operation_q      <= IDLE_OP;
            sample_data_q    <= '0;
            sample_address_q <= '0;
            sample_valid_q   <= 1'b0;
            abort_q          <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            address_q        <= address_d;
            operation_q      <= operation_d;
            sample_data_q    <= sample_data_d;
            sample_address_q <= sample_address_d;
            sample_valid_q   <= sample_valid_d;
            abort_q          <= abort_d;
            done_q           <= done_d;
        end
    end

    assign operation      = operation_q;
    assign address_line   = address_q;
    assign sample_data    = sample_data_q;
    assign sample_address = sample_address_q;
    assign sample_valid   = sample_valid_q;
    assign busy           = (state_q != StIdle);
    assign done           = done_q;

endmodule

// File: tb/tb_rom_sweep_reader.sv
// Bench for rom_sweep_reader: random ROM contents and handshakes, scoreboard of expected samples.
module tb_rom_sweep_reader;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int LAST = 7;
    localparam int S    = 4;
    localparam logic [3:0] RD_OP = 4'b1100;
    localparam logic [3:0] ID_OP = 4'b1111;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          start, abort, step_up, step_down;
    logic [DW-1:0] data_line_in;
    logic [3:0]    operation;
    logic [AW-1:0] address_line;
    logic [DW-1:0] sample_data;
    logic [AW-1:0] sample_address;
    logic          sample_valid, sample_ready, busy, done;

    logic [DW-1:0] rom [0:15];
    exp_t          exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_count = 0;
    int            model_addr;

    rom_sweep_reader #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .LAST_ADDRESS (LAST),
        .SETTLE_CYCLES(S),
        .READ_OP      (RD_OP),
        .IDLE_OP      (ID_OP)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .step_up       (step_up),
        .step_down     (step_down),
        .data_line_in  (data_line_in),
        .operation     (operation),
        .address_line  (address_line),
        .sample_data   (sample_data),
        .sample_address(sample_address),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .busy          (busy),
        .done          (done)
    );

    // Behavioural chip: the data bus always shows the word at the driven address.
    assign data_line_in = rom[address_line];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) exp_q.push_back('{addr: AW'(a), data: rom[a]});
    endtask

    // Monitor: scoreboard pop on every accepted sample, stability check while backpressured.
    logic          pv, pr;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;
    exp_t          e;
    initial pv = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            pv = 1'b0;
        end else begin
            if (done) done_count++;
            if (pv && !pr) begin
                n_checks++;
                if (!(sample_valid && sample_data == pd && sample_address == pa)) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%0b a=%0h d=%0h, expected v=1 a=%0h d=%0h",
                             sample_valid, sample_address, sample_data, pa, pd);
                end
            end
            if (sample_valid && sample_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_sample: got a=%0h d=%0h, expected none",
                             sample_address, sample_data);
                end else begin
                    e = exp_q.pop_front();
                    if (sample_address !== e.addr || sample_data !== e.data) begin
                        n_fail++;
                        $display("FAIL sample: got a=%0h d=%0h, expected a=%0h d=%0h",
                                 sample_address, sample_data, e.addr, e.data);
                    end
                end
            end
            pv = sample_valid;
            pr = sample_ready;
            pd = sample_data;
            pa = sample_address;
        end
    end

    // Starts a sweep and runs until done; optional backpressure hold and abort on an address.
    task automatic run_sweep(input bit with_step, input bit rand_ready, input int hold_addr,
                             input int abort_addr, output int first_valid, output int total);
        int  hold_cnt = 0;
        bit  held = 0;
        bit  armed = 0;
        int  arm = 0;
        first_valid = -1;
        total       = -1;
        start   = 1'b1;
        step_up = with_step;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            step_up = 1'b0;
            abort   = 1'b0;
            if (sample_valid && first_valid < 0) first_valid = n;
            if (done) begin
                total = n;
                break;
            end
            if (abort_addr >= 0 && !armed && address_line == AW'(abort_addr)) begin
                armed = 1;
                arm   = 2;
            end
            #1;
            if (hold_cnt > 0) begin
                sample_ready = 1'b0;
                hold_cnt--;
            end else if (sample_valid && sample_address == AW'(hold_addr) && !held) begin
                sample_ready = 1'b0;
                hold_cnt     = 9;
                held         = 1;
            end else begin
                sample_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (arm > 0) begin
                arm--;
                if (arm == 0) abort = 1'b1;
            end
        end
        if (total < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got no done, expected done");
        end
        #1;
        sample_ready = 1'b1;
    endtask

    // One manual step: the model predicts the address and the sample it should yield.
    task automatic do_step(input bit up, input bit dn);
        if (up && !dn) model_addr = (model_addr + 1) % (LAST + 1);
        if (dn && !up) model_addr = (model_addr + LAST) % (LAST + 1);
        if (up != dn) exp_q.push_back('{addr: AW'(model_addr), data: rom[model_addr]});
        step_up   = up;
        step_down = dn;
        tick();
        step_up   = 1'b0;
        step_down = 1'b0;
        if (up && dn) check("both_steps_idle", 32'(busy), 0);
        for (int n = 0; n < 300 && busy; n++) begin
            sample_ready = 1'($urandom_range(0, 1));
            tick();
        end
        sample_ready = 1'b1;
        check("step_finish", 32'(busy), 0);
        check("step_address", 32'(address_line), model_addr);
    endtask

    int fv, tot, d0, op;

    initial begin
        reset_n = 1'b1;
        start = 0; abort = 0; step_up = 0; step_down = 0; sample_ready = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = ~DW'(i);
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_operation", 32'(operation), 32'(ID_OP));
        check("rst_address", 32'(address_line), 0);
        check("rst_sample_data", 32'(sample_data), 0);
        check("rst_sample_address", 32'(sample_address), 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        tick();

        // Reset mid-SETTLE of a single read of address 1: everything discarded.
        d0 = done_count;
        step_up = 1'b1;
        tick();
        step_up = 1'b0;
        tick();
        tick();
        check("pre_reset_operation", 32'(operation), 32'(RD_OP));
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_operation", 32'(operation), 32'(ID_OP));
        check("mid_rst_address", 32'(address_line), 0);
        check("mid_rst_valid", 32'(sample_valid), 0);
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check("no_done_after_reset", done_count - d0, 0);
        check("idle_after_reset", 32'(busy), 0);

        // Full sweep, ready tied high, data = ~addr.
        d0 = done_count;
        push_range(0, LAST);
        run_sweep(0, 0, -1, -1, fv, tot);
        check("first_valid_latency", fv, S + 2);
        check("sweep_total_cycles", tot, (LAST + 1) * (S + 3));
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("sweep_done_count", done_count - d0, 1);
        check("sweep_idle_op", 32'(operation), 32'(ID_OP));
        check("sweep_end_addr", 32'(address_line), LAST);
        check("sweep_queue_empty", exp_q.size(), 0);

        // Random contents, 10-cycle stall on address 3, random ready elsewhere.
        for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);
        d0 = done_count;
        push_range(0, LAST);
        run_sweep(0, 1, 3, -1, fv, tot);
        tick();
        check("bp_done_count", done_count - d0, 1);
        check("bp_queue_empty", exp_q.size(), 0);

        // Manual steps: wrap up to 0, wrap down to LAST, then random steps.
        d0 = done_count;
        model_addr = LAST;
        do_step(1, 0);
        do_step(0, 1);
        do_step(1, 0);
        do_step(1, 1);
        for (int k = 0; k < 16; k++) begin
            op = int'($urandom_range(0, 2));
            do_step(op != 1, op != 0);
        end
        check("steps_no_done", done_count - d0, 0);
        check("steps_queue_empty", exp_q.size(), 0);

        // Abort while idle does nothing.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check("idle_abort_busy", 32'(busy), 0);
        check("idle_abort_no_done", done_count - d0, 0);

        // start together with step_up: sweep from address 0 wins.
        for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);
        d0 = done_count;
        push_range(0, LAST);
        run_sweep(1, 1, -1, -1, fv, tot);
        tick();
        check("start_step_done", done_count - d0, 1);
        check("start_step_queue_empty", exp_q.size(), 0);

        // Abort during SETTLE of address 2: only addresses 0 and 1 come out.
        d0 = done_count;
        push_range(0, 1);
        run_sweep(0, 0, -1, 2, fv, tot);
        tick();
        check("abort_done_count", done_count - d0, 1);
        check("abort_operation", 32'(operation), 32'(ID_OP));
        check("abort_busy", 32'(busy), 0);
        check("abort_address", 32'(address_line), 2);
        repeat (5) tick();
        check("abort_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
